// File: rtl/spi_tx_engine.sv
// SPI transmit serializer: FIFO-fed, 4..DW bit frames, MSB/LSB first, optional trailing CRC frame.
// Optional feature macro: SPI_TX_CRC_EN builds the CRC register, CRC state and crc_en path.
module spi_tx_engine #(
    parameter int DW         = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 13
) (
    input  logic                          sclk_tx,
    input  logic                          spi_tx_rstn,
    input  logic                          wr_valid,
    input  logic [DW-1:0]                 wr_data,
    output logic                          wr_ready,
    input  logic [$clog2(DW)-1:0]         fsize,
    input  logic                          lsbf,
    input  logic                          rxonly,
    input  logic                          crc_en,
    input  logic [CNT_W-1:0]              tx_num,
    input  logic [DW-1:0]                 crc_poly,
    output logic                          shift_out,
    output logic                          tx_busy,
    output logic                          frame_start,
    output logic                          underrun,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [DW-1:0]                 crc_out
);

    localparam int FS_W = $clog2(DW);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int LW   = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_CRC  = 2'd2
    } state_t;

    // Places bits [fs:0] of d into the LSBs in transmit order; bits above fs are dropped.
    function automatic logic [DW-1:0] order_bits(input logic [DW-1:0] d,
                                                 input logic [FS_W-1:0] fs,
                                                 input logic lsb);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < DW; i++) begin
            if (i <= int'(fs))
                r[FS_W'(i)] = lsb ? d[FS_W'(i)] : d[FS_W'(int'(fs) - i)];
        end
        return r;
    endfunction

    state_t            state;
    state_t            state_next;
    logic [DW-1:0]     shifter;
    logic [FS_W-1:0]   bit_cnt;
    logic [FS_W-1:0]   fsize_l;
    logic              lsbf_l;
    logic [CNT_W-1:0]  frame_cnt;
    logic [DW-1:0]     crc;
    logic [DW-1:0]     crc_next;
    logic              crc_en_eff;

    logic [DW-1:0]     fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [LW-1:0]     count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [DW-1:0]     head;

    logic              load_data;
    logic              load_crc;
    logic              done_set;
    logic              under_set;
    logic              frame_last;
    logic              xfer_end;
    logic [CNT_W-1:0]  tx_num_eff;
    logic [CNT_W:0]    cnt_inc;
    logic [DW-1:0]     load_vec;

    // ------------------------------------------------------------------ FIFO
    assign full  = (count == LW'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign push  = wr_valid & wr_ready;
    assign head  = fifo_mem[rd_ptr];

    // NOTE: storage has no reset; an entry is only read after count marks it written.
    always_ff @(posedge sclk_tx) begin
        if (push)
            fifo_mem[wr_ptr] <= wr_data;
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sclk_tx or negedge spi_tx_rstn) begin
        if (!spi_tx_rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (rxonly) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + LW'(push) - LW'(pop);
        end
    end

    // ------------------------------------------------------------------ CRC
`ifdef SPI_TX_CRC_EN
    function automatic logic [DW-1:0] crc_step(input logic [DW-1:0] c,
                                               input logic b,
                                               input logic [FS_W-1:0] fs,
                                               input logic [DW-1:0] poly);
        logic [DW-1:0] m;
        logic [DW-1:0] r;
        logic          fb;
        m = '0;
        for (int i = 0; i < DW; i++) begin
            if (i <= int'(fs)) m[FS_W'(i)] = 1'b1;
        end
        fb = c[fs] ^ b;
        r  = (c << 1) & m;
        if (fb) r = r ^ (poly & m);
        return r;
    endfunction

    assign crc_en_eff = crc_en;
    assign crc_next   = crc_step(crc, shift_out, fsize_l, crc_poly);

    // The bit on shift_out during a DATA cycle is folded in at the edge that retires it.
    always_ff @(posedge sclk_tx or negedge spi_tx_rstn) begin
        if (!spi_tx_rstn)
            crc <= '0;
        else if (rxonly || !crc_en)
            crc <= '0;
        else if (state == S_DATA)
            crc <= crc_next;
        else if (state == S_CRC && frame_last)
            crc <= '0;
    end
`else
    logic unused_crc_inputs;
    assign unused_crc_inputs = ^{crc_en, crc_poly};
    assign crc_en_eff        = 1'b0;
    assign crc_next          = '0;
    assign crc               = '0;
`endif

    // ------------------------------------------------------------------ FSM
    assign tx_num_eff = (tx_num == '0) ? CNT_W'(1) : tx_num;
    assign cnt_inc    = {1'b0, frame_cnt} + (CNT_W+1)'(1);
    assign xfer_end   = (cnt_inc >= {1'b0, tx_num_eff});
    assign frame_last = (bit_cnt == fsize_l);

    always_ff @(posedge sclk_tx or negedge spi_tx_rstn) begin
        if (!spi_tx_rstn)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load_data  = 1'b0;
        load_crc   = 1'b0;
        done_set   = 1'b0;
        under_set  = 1'b0;
        if (rxonly) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        pop        = 1'b1;
                        load_data  = 1'b1;
                        state_next = S_DATA;
                    end
                end
                S_DATA: begin
                    if (frame_last) begin
                        if (xfer_end && crc_en_eff) begin
                            load_crc   = 1'b1;
                            state_next = S_CRC;
                        end else begin
                            done_set = xfer_end;
                            if (!empty) begin
                                pop        = 1'b1;
                                load_data  = 1'b1;
                                state_next = S_DATA;
                            end else begin
                                under_set  = !xfer_end;
                                state_next = S_IDLE;
                            end
                        end
                    end
                end
                S_CRC: begin
                    if (frame_last) begin
                        done_set = 1'b1;
                        if (!empty) begin
                            pop        = 1'b1;
                            load_data  = 1'b1;
                            state_next = S_DATA;
                        end else begin
                            state_next = S_IDLE;
                        end
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        tx_busy    = (state != S_IDLE);
        wr_ready   = !full && !rxonly;
        fifo_level = count;
        crc_out    = crc;
    end

    // ------------------------------------------------------------------ datapath
    assign load_vec = load_crc ? order_bits(crc_next, fsize_l, lsbf_l)
                               : order_bits(head, fsize, lsbf);

    always_ff @(posedge sclk_tx or negedge spi_tx_rstn) begin
        if (!spi_tx_rstn) begin
            shifter     <= '0;
            bit_cnt     <= '0;
            fsize_l     <= '0;
            lsbf_l      <= 1'b0;
            frame_cnt   <= '0;
            shift_out   <= 1'b0;
            frame_start <= 1'b0;
            tx_done     <= 1'b0;
            underrun    <= 1'b0;
        end else if (rxonly) begin
            shifter     <= '0;
            bit_cnt     <= '0;
            frame_cnt   <= '0;
            shift_out   <= 1'b0;
            frame_start <= 1'b0;
            tx_done     <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= load_data | load_crc;
            tx_done     <= done_set;
            underrun    <= under_set;

            // First bit goes straight to the pin on the load edge, so frames abut.
            if (load_data || load_crc) begin
                shifter   <= load_vec >> 1;
                shift_out <= load_vec[0];
                bit_cnt   <= '0;
            end else if (state_next == S_IDLE) begin
                shifter   <= '0;
                shift_out <= 1'b0;
                bit_cnt   <= '0;
            end else begin
                shifter   <= shifter >> 1;
                shift_out <= shifter[0];
                bit_cnt   <= bit_cnt + FS_W'(1);
            end

            if (load_data) begin
                fsize_l <= fsize;
                lsbf_l  <= lsbf;
            end

            if (state == S_DATA && frame_last)
                frame_cnt <= (xfer_end && !crc_en_eff) ? '0 : cnt_inc[CNT_W-1:0];
            else if (state == S_CRC && frame_last)
                frame_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_spi_tx_engine.sv
// Self-checking bench for spi_tx_engine: frame-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_spi_tx_engine;

    localparam int DW         = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = 13;
    localparam int FS_W       = $clog2(DW);
    localparam int LW         = $clog2(FIFO_DEPTH) + 1;
`ifdef SPI_TX_CRC_EN
    localparam bit CRC_BUILT = 1'b1;
`else
    localparam bit CRC_BUILT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_valid;
    logic [DW-1:0]     wr_data;
    logic              wr_ready;
    logic [FS_W-1:0]   fsize;
    logic              lsbf;
    logic              rxonly;
    logic              crc_en;
    logic [CNT_W-1:0]  tx_num;
    logic [DW-1:0]     crc_poly;
    logic              shift_out;
    logic              tx_busy;
    logic              frame_start;
    logic              underrun;
    logic              tx_done;
    logic [LW-1:0]     fifo_level;
    logic [DW-1:0]     crc_out;

    int checks   = 0;
    int failures = 0;

    spi_tx_engine #(.DW(DW), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
        .sclk_tx     (clk),
        .spi_tx_rstn (rst_n),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .fsize       (fsize),
        .lsbf        (lsbf),
        .rxonly      (rxonly),
        .crc_en      (crc_en),
        .tx_num      (tx_num),
        .crc_poly    (crc_poly),
        .shift_out   (shift_out),
        .tx_busy     (tx_busy),
        .frame_start (frame_start),
        .underrun    (underrun),
        .tx_done     (tx_done),
        .fifo_level  (fifo_level),
        .crc_out     (crc_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- reference model
    // Frames become a queue of bits in wire order; one bit leaves per clock.
    typedef enum {K_NONE, K_DATA, K_CRC} kind_t;

    logic [DW-1:0] mq[$];
    bit            mb[$];
    kind_t         kind = K_NONE;
    int            frames = 0;
    int            cur_fs = 0;
    bit            cur_lsbf = 1'b0;
    logic [DW-1:0] m_crc = '0;
    bit            pend_valid = 1'b0;
    bit            pend_bit = 1'b0;
    bit            m_wr;
    bit            m_load;
    bit            crc_on;
    int            m_txn;
    bit            e_shift = 1'b0, e_fs = 1'b0, e_done = 1'b0, e_under = 1'b0, e_busy = 1'b0;
    int            e_level = 0;
    logic [DW-1:0] e_crc = '0;

    function automatic logic [DW-1:0] m_step(logic [DW-1:0] c, bit b, int fs, logic [DW-1:0] poly);
        logic [DW-1:0] m = '0;
        logic [DW-1:0] r;
        for (int i = 0; i <= fs; i++) m[i] = 1'b1;
        r = (c << 1) & m;
        if (c[fs] ^ b) r = r ^ (poly & m);
        return r;
    endfunction

    task automatic m_push_bits(input logic [DW-1:0] d, input int fs, input bit lsb);
        for (int k = 0; k <= fs; k++) mb.push_back(lsb ? d[k] : d[fs - k]);
    endtask

    task automatic m_clear();
        mq.delete();
        mb.delete();
        kind = K_NONE;
        frames = 0;
        m_crc = '0;
        pend_valid = 1'b0;
        e_shift = 1'b0; e_fs = 1'b0; e_done = 1'b0; e_under = 1'b0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_clear();
        end else begin
            crc_on = CRC_BUILT && crc_en;
            m_txn  = (tx_num == 0) ? 1 : int'(tx_num);
            m_wr   = wr_valid && !rxonly && (mq.size() < FIFO_DEPTH);
            e_fs = 1'b0; e_done = 1'b0; e_under = 1'b0;
            if (rxonly) begin
                m_clear();
            end else begin
                if (pend_valid && crc_on) m_crc = m_step(m_crc, pend_bit, cur_fs, crc_poly);
                pend_valid = 1'b0;
                if (!crc_on) m_crc = '0;
                if (mb.size() != 0) begin
                    e_shift = mb.pop_front();
                    if (kind == K_DATA) begin pend_bit = e_shift; pend_valid = 1'b1; end
                end else begin
                    m_load = 1'b1;
                    if (kind == K_DATA) begin
                        frames++;
                        if (frames >= m_txn) begin
                            if (crc_on) begin
                                m_push_bits(m_crc, cur_fs, cur_lsbf);
                                kind = K_CRC; e_fs = 1'b1; e_shift = mb.pop_front(); m_load = 1'b0;
                            end else begin
                                e_done = 1'b1; frames = 0;
                            end
                        end else if (mq.size() == 0) begin
                            e_under = 1'b1;
                        end
                    end else if (kind == K_CRC) begin
                        e_done = 1'b1; frames = 0; m_crc = '0;
                    end
                    if (m_load) begin
                        if (mq.size() != 0) begin
                            cur_fs = int'(fsize); cur_lsbf = lsbf;
                            m_push_bits(mq.pop_front(), cur_fs, cur_lsbf);
                            kind = K_DATA; e_fs = 1'b1; e_shift = mb.pop_front();
                            pend_bit = e_shift; pend_valid = 1'b1;
                        end else begin
                            kind = K_NONE; e_shift = 1'b0;
                        end
                    end
                end
            end
            if (m_wr) mq.push_back(wr_data);
        end
        e_level = mq.size();
        e_busy  = (kind != K_NONE);
        e_crc   = m_crc;
    end

    // Single compare process, 1 time unit after each active edge.
    always @(posedge clk) begin
        #1;
        check("shift_out",   shift_out,   e_shift);
        check("tx_busy",     tx_busy,     e_busy);
        check("frame_start", frame_start, e_fs);
        check("tx_done",     tx_done,     e_done);
        check("underrun",    underrun,    e_under);
        check("fifo_level",  fifo_level,  e_level);
        check("crc_out",     crc_out,     e_crc);
        check("wr_ready",    wr_ready,    (e_level < FIFO_DEPTH) && !rxonly);
    end

    // ---------------------------------------------------------------- stimulus
    task automatic cyc();
        @(posedge clk);
        #3;
    endtask

    logic [23:0] cap;
    int n_fs, n_done, n_under, n_busy;
    logic [DW-1:0] crc_mid;

    initial begin
        rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; fsize = 5'd7; lsbf = 1'b0;
        rxonly = 1'b0; crc_en = 1'b0; tx_num = 13'd1; crc_poly = 32'h07;
        repeat (3) cyc();
        check("rst_shift_out", shift_out, 1'b0);
        check("rst_tx_busy", tx_busy, 1'b0);
        check("rst_fifo_level", fifo_level, 0);
        check("rst_wr_ready", wr_ready, 1'b1);
        rst_n = 1'b1;
        cyc();

        // 1: 0xA5 MSB-first, 8 bits
        wr_valid = 1'b1; wr_data = 32'hA5; cyc(); wr_valid = 1'b0;
        cap = '0; n_fs = 0; n_busy = 0; n_done = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (i < 8) cap = {cap[22:0], shift_out};
            n_fs += int'(frame_start); n_busy += int'(tx_busy); n_done += int'(tx_done);
        end
        check("t1_bits", cap[7:0], 8'b1010_0101);
        check("t1_frame_start", n_fs, 1);
        check("t1_busy_cycles", n_busy, 8);
        check("t1_tx_done", n_done, 1);

        // 2: two 12-bit LSB-first frames back to back
        fsize = 5'd11; lsbf = 1'b1; tx_num = 13'd2;
        wr_valid = 1'b1; wr_data = 32'h3C1; cyc();
        wr_data = 32'h0F0; cyc(); wr_valid = 1'b0;
        cap = {23'd0, shift_out}; n_fs = int'(frame_start); n_busy = int'(tx_busy);
        for (int i = 1; i < 24; i++) begin
            cyc();
            cap = {cap[22:0], shift_out};
            n_fs += int'(frame_start); n_busy += int'(tx_busy);
        end
        check("t2_bits", cap, 24'b100000111100_000011110000);
        check("t2_frame_start", n_fs, 2);
        check("t2_no_gap", n_busy, 24);
        repeat (2) cyc();

        // 3: CRC-8 poly 0x07 over 0x01 gives 0x07
        fsize = 5'd7; lsbf = 1'b0; tx_num = 13'd1; crc_en = 1'b1; crc_poly = 32'h07;
        wr_valid = 1'b1; wr_data = 32'h01; cyc(); wr_valid = 1'b0;
        cap = '0; n_fs = 0; n_done = 0; crc_mid = '0;
        for (int i = 0; i < 18; i++) begin
            cyc();
            if (i < 16) cap = {cap[22:0], shift_out};
            if (i == 8) crc_mid = crc_out;
            n_fs += int'(frame_start); n_done += int'(tx_done);
        end
        check("t3_bits", cap[15:0], CRC_BUILT ? 16'b00000001_00000111 : 16'b00000001_00000000);
        check("t3_crc_value", crc_mid, CRC_BUILT ? 32'h07 : 32'h0);
        check("t3_frame_start", n_fs, CRC_BUILT ? 2 : 1);
        check("t3_tx_done", n_done, 1);
        crc_en = 1'b0;
        cyc();

        // 4: tx_num=3 but only two frames supplied
        tx_num = 13'd3;
        wr_valid = 1'b1; wr_data = 32'h12; cyc();
        wr_data = 32'h34; cyc(); wr_valid = 1'b0;
        n_under = 0; n_done = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            n_under += int'(underrun); n_done += int'(tx_done);
        end
        check("t4_underrun", n_under, 1);
        check("t4_no_done", n_done, 0);
        check("t4_idle", tx_busy, 1'b0);
        check("t4_fifo_empty", fifo_level, 0);

        // 5: fill FIFO, then abort with rxonly mid-frame
        tx_num = 13'd1;
        wr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_data = 32'hFF; cyc();
        end
        wr_valid = 1'b0;
        check("t5_full_level", fifo_level, 4);
        check("t5_full_ready", wr_ready, 1'b0);
        cyc();
        check("t5_mid_frame_bit", shift_out, 1'b1);
        rxonly = 1'b1; cyc();
        check("t5_abort_shift", shift_out, 1'b0);
        check("t5_abort_busy", tx_busy, 1'b0);
        check("t5_abort_level", fifo_level, 0);
        check("t5_abort_ready", wr_ready, 1'b0);
        rxonly = 1'b0; cyc();
        check("t5_ready_again", wr_ready, 1'b1);

        // 6: async reset during the CRC frame (CRC of 0xFF is 0xF3)
        crc_en = 1'b1; crc_poly = 32'h07;
        wr_valid = 1'b1; wr_data = 32'hFF; cyc(); wr_valid = 1'b0;
        repeat (10) cyc();
        check("t6_busy_in_crc", tx_busy, CRC_BUILT);
        check("t6_crc_pre_reset", crc_out, CRC_BUILT ? 32'hF3 : 32'h0);
        rst_n = 1'b0; #1;
        check("t6_rst_shift", shift_out, 1'b0);
        check("t6_rst_busy", tx_busy, 1'b0);
        check("t6_rst_fs", frame_start, 1'b0);
        check("t6_rst_done", tx_done, 1'b0);
        check("t6_rst_crc", crc_out, 32'h0);
        check("t6_rst_level", fifo_level, 0);
        cyc();
        rst_n = 1'b1; crc_en = 1'b0;
        cyc();
        check("t6_ready_after", wr_ready, 1'b1);
        check("t6_idle_after", tx_busy, 1'b0);

        repeat (2) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_tx_engine.md
# spi_tx_engine

Parametrised SPI transmit serializer; next generation of the fixed 8/16/32-bit transmit shifter. Accepts frames through a valid/ready write port into an internal FIFO, serializes any frame size from 4 to DW bits, MSB- or LSB-first, and appends a serially computed CRC frame after a programmed frame count. Sits between the SPI register/DMA interface and the MOSI/MISO pad mux, clocked by the SPI bit clock.

## Interface
- DW, 32: maximum frame width in bits; power of 2, 8..32.
- FIFO_DEPTH, 4: transmit FIFO entries; power of 2, ≥2.
- CNT_W, 13: frame counter width.

- sclk_tx  in  1  SPI bit clock; one bit shifted per rising edge.
- spi_tx_rstn  in  1  asynchronous active-low reset.
- wr_valid  in  1  write request.
- wr_data  in  DW  frame data, right-justified.
- wr_ready  out  1  = !full & !rxonly; write accepted when wr_valid & wr_ready.
- fsize  in  $clog2(DW)  frame bits minus 1; legal 3..DW-1; latched at each frame load.
- lsbf  in  1  1 = LSB first, 0 = MSB first; latched at load.
- rxonly  in  1  synchronous abort/hold.
- crc_en  in  1  enable CRC accumulation and CRC frame.
- tx_num  in  CNT_W  data frames per transfer; 0 is treated as 1.
- crc_poly  in  DW  CRC polynomial, low fsize+1 bits used, implicit top term.
- shift_out  out  1  serial data (registered).
- tx_busy  out  1  state != IDLE.
- frame_start  out  1  one-cycle pulse on every data or CRC frame load.
- underrun  out  1  one-cycle pulse when a data frame ends, more are due, and FIFO is empty.
- tx_done  out  1  one-cycle pulse on last bit of transfer (last data frame, or CRC frame).
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries.
- crc_out  out  DW  current CRC register, zero-extended.

## Operation
- States: IDLE, DATA, CRC. All registered outputs reset to 0; wr_ready = 1 after reset when rxonly = 0.
- IDLE: shift_out = 0. If FIFO non-empty and !rxonly: pop, load shifter, bit_cnt = 0, frame_start = 1, go DATA.
- Load: MSB-first reverses bits [fsize:0] into shifter LSBs; bits above fsize ignored. shift_out = shifter[0] each cycle after load, shifter shifts right.
- DATA end (bit_cnt == fsize_latched): frame_cnt += 1, then in priority:
  - frame_cnt+1 ≥ tx_num and crc_en: load CRC (same lsbf ordering, final bit included), frame_start, go CRC.
  - frame_cnt+1 ≥ tx_num and !crc_en: tx_done, frame_cnt = 0; continue as below (next transfer).
  - FIFO non-empty: pop and load next frame, no idle gap.
  - else: underrun pulse only if frame_cnt+1 < tx_num; go IDLE.
- CRC: shift fsize+1 bits; on last bit tx_done, frame_cnt = 0, crc cleared, go IDLE (or load next frame if FIFO non-empty).
- CRC update per DATA bit b: fb = crc[fsize] ^ b; crc = ((crc << 1) masked to fsize+1 bits) ^ (fb ? crc_poly : 0). Init 0; held at 0 while crc_en = 0.
- rxonly = 1: next edge state = IDLE, shifter, bit_cnt, frame_cnt, crc cleared, FIFO flushed; writes refused.
- FIFO: write and pop in same cycle when full: pop succeeds, write refused (wr_ready already 0); when empty: no pop.

## Timing
- Write accepted at edge N → fifo_level updates at N; IDLE load at edge N+1; first bit on shift_out after N+1.
- Each frame occupies exactly fsize+1 cycles; consecutive frames and CRC frame back-to-back.
- frame_start, tx_done, underrun valid in the cycle after the edge causing them, one cycle wide.
- fsize/lsbf changes mid-frame take effect at the next load only.

## Configuration
- SPI_TX_CRC_EN defined: CRC register, CRC state and crc_en path built.
- Undefined: crc_en ignored (treated 0), CRC state unreachable, crc_out tied 0; tx_num still drives tx_done.

## Test plan
- fsize=7, lsbf=0, write 0xA5 → shift_out 1,0,1,0,0,1,0,1, frame_start once, tx_busy 8 cycles.
- fsize=11, lsbf=1, write 0x3C1, 0x0F0 back-to-back → 24 consecutive bits, no gap, two frame_start pulses.
- fsize=7, crc_en=1, crc_poly=0x07, tx_num=1, data 0x01 → CRC frame 0x07 sent MSB-first, tx_done on its last bit.
- tx_num=3, write 2 frames only → underrun after frame 2, state IDLE, fifo_level 0.
- Fill FIFO to 4 → wr_ready 0; raise rxonly mid-frame → next cycle shift_out 0, tx_busy 0, fifo_level 0.
- Reset asserted mid-CRC frame → all outputs 0 immediately; after release, wr_ready 1.
